fe_arb: RTL

- Arbitrates the single Avalon front-end service channel between several IO devices that each raise a level data request (fe_data_rq style) and expose a read-to-acknowledge data word: paper tape punch, paper tape reader, teletype, etc.
- Presents one interrupt line and a two-word Avalon slave to the front end.
- Grants one device at a time, round-robin.
- Forwards the front end's data read to the granted device as its s_read pulse.
- A watchdog stops a stalled front end from locking out all devices.

---
 rtl/fe_arb_pkg.sv | 29 ++
 rtl/fe_arb_if.sv | 35 +++
 rtl/fe_arb_rr_pick.sv | 36 +++
 rtl/fe_arb.sv | 117 +++++++++++
 4 files changed

// File: rtl/fe_arb_pkg.sv
// Shared definitions for the front-end service-channel arbiter:
// FSM encoding, status word layout and Avalon address map.
package fe_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OFFER = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  localparam int STAT_VALID  = 31;
  localparam int STAT_ERR    = 30;
  localparam int STAT_ID_LSB = 0;
  localparam int STAT_ID_W   = 8;

  localparam logic ADDR_STATUS = 1'b0;
  localparam logic ADDR_DATA   = 1'b1;

  function automatic logic [31:0] status_word(input logic valid, input logic err,
                                              input logic [STAT_ID_W-1:0] id);
    logic [31:0] w;
    w = '0;
    w[STAT_VALID] = valid;
    w[STAT_ERR] = err;
    w[STAT_ID_LSB +: STAT_ID_W] = id;
    return w;
  endfunction

endpackage

// File: rtl/fe_arb_if.sv
// Device request/data bundle plus the front end's two-word Avalon slave.
// The arbiter takes the slave modport; the environment drives the master side.
interface fe_arb_if #(
  parameter int N = 4
);

  logic [N-1:0]    dev_rq;
  logic [32*N-1:0] dev_readdata;
  logic [N-1:0]    dev_read;
  logic            s_address;
  logic            s_read;
  logic [31:0]     s_readdata;
  logic            fe_irq;

  modport slave (
    input  dev_rq,
    input  dev_readdata,
    input  s_address,
    input  s_read,
    output dev_read,
    output s_readdata,
    output fe_irq
  );

  modport master (
    output dev_rq,
    output dev_readdata,
    output s_address,
    output s_read,
    input  dev_read,
    input  s_readdata,
    input  fe_irq
  );

endinterface

// File: rtl/fe_arb_rr_pick.sv
// Rotating priority encoder: returns the first set request at or above ptr,
// wrapping modulo N.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [IDX_W-1:0] idx
);

  localparam logic [IDX_W:0] N_W = (IDX_W+1)'(N);

  logic [IDX_W-1:0] cand [N];
  logic [N-1:0]     req_rot;

  // cand[gi] is the device index searched at distance gi from ptr
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_rot
      logic [IDX_W:0] sum;
      assign sum         = {1'b0, ptr} + (IDX_W+1)'(gi);
      assign cand[gi]    = (sum >= N_W) ? IDX_W'(sum - N_W) : sum[IDX_W-1:0];
      assign req_rot[gi] = req[cand[gi]];
    end
  endgenerate

  always_comb begin
    any = |req;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_rot[i]) idx = cand[i];
    end
  end

endmodule

// File: rtl/fe_arb.sv
// Round-robin arbiter granting one IO device at a time to the front end,
// with a watchdog that aborts an offer the front end never services.
module fe_arb
  import fe_arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int TMO   = 1000000,
  parameter int CNT_W = 20
) (
  input logic   clk,
  input logic   reset,
  fe_arb_if.slave bus
);

  localparam int               IDX_W     = $clog2(N);
  localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(TMO - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] wdog_q, wdog_d;
  logic             fe_irq_q, fe_irq_d;

  logic             pick_any;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W-1:0] grant_next;
  logic [31:0]      dev_word [N];
  logic             status_rd, data_rd, serve;

  rr_pick #(
    .N    (N),
    .IDX_W(IDX_W)
  ) u_pick (
    .req(bus.dev_rq),
    .ptr(ptr_q),
    .any(pick_any),
    .idx(pick_idx)
  );

  assign status_rd  = bus.s_read && (bus.s_address == ADDR_STATUS);
  assign data_rd    = bus.s_read && (bus.s_address == ADDR_DATA);
  // Reset suppresses the strobe so an aborted grant never reaches its device
  assign serve      = data_rd && (state_q == ST_OFFER) && !reset;
  assign grant_next = (grant_q == IDX_W'(N - 1)) ? '0 : grant_q + 1'b1;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_dev
      assign dev_word[gi]     = bus.dev_readdata[32*gi +: 32];
      assign bus.dev_read[gi] = serve && (grant_q == IDX_W'(gi));
    end
  endgenerate

  always_comb begin
    bus.s_readdata = '0;
    if (status_rd) begin
      bus.s_readdata = status_word(state_q == ST_OFFER, err_q, STAT_ID_W'(grant_q));
    end else if (serve) begin
      bus.s_readdata = dev_word[grant_q];
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    wdog_d  = wdog_q;
    err_d   = status_rd ? 1'b0 : err_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          grant_d = pick_idx;
          wdog_d  = '0;
          state_d = ST_OFFER;
        end
      end
      ST_OFFER: begin
        wdog_d = wdog_q + 1'b1;
        // Data read beats a request drop, which beats the watchdog
        if (data_rd) begin
          ptr_d   = grant_next;
          state_d = ST_HOLD;
        end else if (!bus.dev_rq[grant_q]) begin
          state_d = ST_IDLE;
        end else if (wdog_q == WDOG_LAST) begin
          err_d   = 1'b1;
          ptr_d   = grant_next;
          state_d = ST_IDLE;
        end
      end
      ST_HOLD: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    fe_irq_d = (state_d == ST_OFFER);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      grant_q  <= '0;
      err_q    <= 1'b0;
      wdog_q   <= '0;
      fe_irq_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      grant_q  <= grant_d;
      err_q    <= err_d;
      wdog_q   <= wdog_d;
      fe_irq_q <= fe_irq_d;
    end
  end

  assign bus.fe_irq = fe_irq_q;

endmodule
